// File: rtl/lif_neuron_bank.sv
// lif_neuron_bank: time-multiplexed bank of leaky integrate-and-fire neurons.
//
// Input currents are accumulated into per-neuron membrane potentials while in
// ACCUM. A step pulse starts an UPDATE sweep that processes one neuron per
// cycle, applying refractory hold-off, leak, threshold and negative floor.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   in_valid     input current valid (dropped unless in_ready)
//   in_ready     high only in ACCUM
//   in_idx       target neuron of the input current
//   in_cur       signed input current
//   step         time-step tick (single-cycle pulse)
//   spike_valid  one-cycle spike event, spike_idx names the firing neuron
//   upd_done     one-cycle pulse as the sweep's last neuron is processed
//   overrun      sticky: step seen outside ACCUM, cleared only by rst
//   dbg_idx      potential readback select, dbg_pot = pot[dbg_idx]
module lif_neuron_bank #(
    parameter int unsigned N_NEURON   = 4,
    parameter int unsigned IN_W       = 10,
    parameter int unsigned POT_W      = 12,
    parameter int          THRESH     = 200,
    parameter int unsigned LEAK_SHIFT = 3,
    parameter int unsigned REFRAC     = 2,
    localparam int unsigned IDX_W     = $clog2(N_NEURON)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IDX_W-1:0]        in_idx,
    input  logic signed [IN_W-1:0]  in_cur,
    input  logic                    step,
    output logic                    spike_valid,
    output logic [IDX_W-1:0]        spike_idx,
    output logic                    upd_done,
    output logic                    overrun,
    input  logic [IDX_W-1:0]        dbg_idx,
    output logic signed [POT_W-1:0] dbg_pot
);

    localparam int unsigned RC_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    localparam logic ST_ACCUM  = 1'b0;
    localparam logic ST_UPDATE = 1'b1;

    localparam logic signed [POT_W-1:0] POS_TH  = POT_W'(THRESH);
    localparam logic signed [POT_W-1:0] NEG_TH  = POT_W'(-THRESH);
    localparam logic signed [POT_W-1:0] POT_MAX = {1'b0, {(POT_W-1){1'b1}}};
    localparam logic signed [POT_W-1:0] POT_MIN = {1'b1, {(POT_W-1){1'b0}}};
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_NEURON - 1);
    localparam logic [RC_W-1:0]         RC_LOAD  = RC_W'(REFRAC);

    logic                    state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [POT_W-1:0] pot_q [N_NEURON];
    logic [RC_W-1:0]         rcnt_q [N_NEURON];
    logic                    spike_valid_q, spike_valid_d;
    logic [IDX_W-1:0]        spike_idx_q, spike_idx_d;
    logic                    upd_done_q, upd_done_d;
    logic                    overrun_q, overrun_d;

    logic [POT_W:0]          acc_sum;
    logic signed [POT_W-1:0] acc_sat;
    logic signed [POT_W-1:0] cur_pot, leak_v;
    logic                    pot_we;
    logic [IDX_W-1:0]        pot_widx;
    logic signed [POT_W-1:0] pot_wval;
    logic                    rc_we;
    logic [RC_W-1:0]         rc_wval;

    // Saturating accumulate, computed one bit wider than the potential.
    always_comb begin
        acc_sum = {pot_q[in_idx][POT_W-1], pot_q[in_idx]}
                + {{(POT_W + 1 - IN_W){in_cur[IN_W-1]}}, in_cur};
        if (acc_sum[POT_W] != acc_sum[POT_W-1]) begin
            acc_sat = acc_sum[POT_W] ? POT_MIN : POT_MAX;
        end else begin
            acc_sat = acc_sum[POT_W-1:0];
        end
    end

    always_comb begin
        cur_pot = pot_q[idx_q];
        leak_v  = cur_pot - (cur_pot >>> LEAK_SHIFT);
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        spike_valid_d = 1'b0;
        spike_idx_d   = spike_idx_q;
        upd_done_d    = 1'b0;
        overrun_d     = overrun_q;
        pot_we        = 1'b0;
        pot_widx      = in_idx;
        pot_wval      = acc_sat;
        rc_we         = 1'b0;
        rc_wval       = rcnt_q[idx_q];

        case (state_q)
            ST_ACCUM: begin
                // An input coinciding with step is still accumulated; the
                // sweep reads it from the register on the following cycle.
                pot_we = in_valid;
                if (step) begin
                    state_d = ST_UPDATE;
                    idx_d   = '0;
                end
            end
            default: begin
                if (step) begin
                    overrun_d = 1'b1;
                end
                pot_we   = 1'b1;
                pot_widx = idx_q;
                if (rcnt_q[idx_q] != '0) begin
                    // Refractory: anything accumulated meanwhile is discarded.
                    pot_wval = '0;
                    rc_we    = 1'b1;
                    rc_wval  = rcnt_q[idx_q] - RC_W'(1);
                end else if (leak_v >= POS_TH) begin
                    pot_wval      = '0;
                    rc_we         = 1'b1;
                    rc_wval       = RC_LOAD;
                    spike_valid_d = 1'b1;
                    spike_idx_d   = idx_q;
                end else begin
                    pot_wval = (leak_v < NEG_TH) ? NEG_TH : leak_v;
                end
                if (idx_q == LAST_IDX) begin
                    state_d    = ST_ACCUM;
                    idx_d      = '0;
                    upd_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_ACCUM;
            idx_q         <= '0;
            spike_valid_q <= 1'b0;
            spike_idx_q   <= '0;
            upd_done_q    <= 1'b0;
            overrun_q     <= 1'b0;
            for (int i = 0; i < int'(N_NEURON); i++) begin
                pot_q[i]  <= '0;
                rcnt_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            spike_valid_q <= spike_valid_d;
            spike_idx_q   <= spike_idx_d;
            upd_done_q    <= upd_done_d;
            overrun_q     <= overrun_d;
            if (pot_we) begin
                pot_q[pot_widx] <= pot_wval;
            end
            if (rc_we) begin
                rcnt_q[idx_q] <= rc_wval;
            end
        end
    end

    assign in_ready    = (state_q == ST_ACCUM);
    assign spike_valid = spike_valid_q;
    assign spike_idx   = spike_idx_q;
    assign upd_done    = upd_done_q;
    assign overrun     = overrun_q;
    assign dbg_pot     = pot_q[dbg_idx];

endmodule

// File: tb/tb_lif_neuron_bank.sv
// Self-checking bench for lif_neuron_bank against a plain-integer neuron model.
module tb_lif_neuron_bank;

    localparam int N      = 4;
    localparam int IW     = 2;
    localparam int IN_W   = 10;
    localparam int POT_W  = 12;
    localparam int THRESH = 200;
    localparam int LS     = 3;
    localparam int REFRAC = 2;
    localparam int PMAX   = 2047;
    localparam int PMIN   = -2048;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [IW-1:0]           in_idx = '0;
    logic signed [IN_W-1:0]  in_cur = '0;
    logic                    step = 1'b0;
    logic                    spike_valid;
    logic [IW-1:0]           spike_idx;
    logic                    upd_done;
    logic                    overrun;
    logic [IW-1:0]           dbg_idx = '0;
    logic signed [POT_W-1:0] dbg_pot;

    always #5 clk = ~clk;

    lif_neuron_bank #(
        .N_NEURON(N), .IN_W(IN_W), .POT_W(POT_W), .THRESH(THRESH),
        .LEAK_SHIFT(LS), .REFRAC(REFRAC)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_idx(in_idx), .in_cur(in_cur), .step(step),
        .spike_valid(spike_valid), .spike_idx(spike_idx), .upd_done(upd_done),
        .overrun(overrun), .dbg_idx(dbg_idx), .dbg_pot(dbg_pot)
    );

    int m_pot [N];
    int m_rc  [N];
    bit m_ovr;
    bit exp_sv [N];
    bit obs_sv [N];
    int obs_si [N];
    bit obs_done [N];
    bit obs_rdy [N];
    int obs_pot [N];
    int n_cmp = 0;
    int n_fail = 0;

    // floor(p / 2^LS) for any sign
    function automatic int floor_div(int p);
        int d = 1 << LS;
        if (p >= 0) return p / d;
        return -((-p + d - 1) / d);
    endfunction

    function automatic int sat(int s);
        if (s > PMAX) return PMAX;
        if (s < PMIN) return PMIN;
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pot[i] = 0;
            m_rc[i]  = 0;
        end
        m_ovr = 0;
    endtask

    task automatic model_sweep();
        int v;
        for (int i = 0; i < N; i++) begin
            exp_sv[i] = 0;
            if (m_rc[i] > 0) begin
                m_pot[i] = 0;
                m_rc[i]--;
            end else begin
                v = m_pot[i] - floor_div(m_pot[i]);
                if (v >= THRESH) begin
                    exp_sv[i] = 1;
                    m_pot[i]  = 0;
                    m_rc[i]   = REFRAC;
                end else begin
                    m_pot[i] = (v < -THRESH) ? -THRESH : v;
                end
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic send(input int i, input int c);
        @(negedge clk);
        in_valid = 1'b1;
        in_idx   = i[IW-1:0];
        in_cur   = c[IN_W-1:0];
        @(negedge clk);
        in_valid = 1'b0;
        m_pot[i] = sat(m_pot[i] + c);
    endtask

    task automatic read_pots();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            dbg_idx = i[IW-1:0];
            #1;
            obs_pot[i] = int'(dbg_pot);
        end
    endtask

    // Runs one sweep; step_at >= 0 re-pulses step in that UPDATE cycle.
    task automatic do_sweep(input int step_at, input bit with_in, input int in_i,
                            input int in_c);
        @(negedge clk);
        step = 1'b1;
        if (with_in) begin
            in_valid = 1'b1;
            in_idx   = in_i[IW-1:0];
            in_cur   = in_c[IN_W-1:0];
        end
        @(posedge clk);
        #1;
        step     = 1'b0;
        in_valid = 1'b0;
        if (with_in) m_pot[in_i] = sat(m_pot[in_i] + in_c);
        model_sweep();
        if (step_at >= 0) m_ovr = 1;
        for (int k = 0; k < N; k++) begin
            step = (k == step_at);
            @(posedge clk);
            #1;
            step        = 1'b0;
            obs_sv[k]   = spike_valid;
            obs_si[k]   = int'(spike_idx);
            obs_done[k] = upd_done;
            obs_rdy[k]  = in_ready;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({spike_valid, upd_done, overrun, in_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset outputs sv/done/ovr/rdy=%b required 0001",
                     {spike_valid, upd_done, overrun, in_ready});
        end
        read_pots();
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (obs_pot[i] !== 0) begin
                n_fail++;
                $display("FAIL reset pot[%0d]=%0d required 0", i, obs_pot[i]);
            end
        end
    endtask

    task automatic test_fire();
        send(2, 146);
        send(2, 96);
        read_pots();
        n_cmp++;
        if (obs_pot[2] !== m_pot[2]) begin
            n_fail++;
            $display("FAIL fire pre-step pot[2]=%0d required %0d", obs_pot[2], m_pot[2]);
        end
        do_sweep(-1, 0, 0, 0);
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if (obs_sv[k] !== exp_sv[k] || (exp_sv[k] && obs_si[k] !== k) ||
                obs_done[k] !== (k == N - 1) || obs_rdy[k] !== (k == N - 1)) begin
                n_fail++;
                $display("FAIL fire slot%0d sv=%0b idx=%0d done=%0b rdy=%0b required sv=%0b idx=%0d done/rdy=%0b",
                         k, obs_sv[k], obs_si[k], obs_done[k], obs_rdy[k], exp_sv[k], k, k == N - 1);
            end
        end
        read_pots();
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (obs_pot[i] !== m_pot[i]) begin
                n_fail++;
                $display("FAIL fire pot[%0d]=%0d required %0d", i, obs_pot[i], m_pot[i]);
            end
        end
    endtask

    task automatic test_refractory();
        for (int r = 0; r < 3; r++) begin
            send(2, 300);
            do_sweep(-1, 0, 0, 0);
            for (int k = 0; k < N; k++) begin
                n_cmp++;
                if (obs_sv[k] !== exp_sv[k] || (exp_sv[k] && obs_si[k] !== k)) begin
                    n_fail++;
                    $display("FAIL refrac step%0d slot%0d sv=%0b idx=%0d required sv=%0b idx=%0d",
                             r + 1, k, obs_sv[k], obs_si[k], exp_sv[k], k);
                end
            end
            read_pots();
            n_cmp++;
            if (obs_pot[2] !== m_pot[2]) begin
                n_fail++;
                $display("FAIL refrac step%0d pot[2]=%0d required %0d", r + 1, obs_pot[2], m_pot[2]);
            end
        end
    endtask

    task automatic test_leak_negative();
        apply_reset();
        send(0, 160);
        send(1, -30);
        for (int r = 0; r < 2; r++) begin
            do_sweep(-1, 0, 0, 0);
            for (int k = 0; k < N; k++) begin
                n_cmp++;
                if (obs_sv[k] !== exp_sv[k]) begin
                    n_fail++;
                    $display("FAIL leak step%0d slot%0d sv=%0b required %0b",
                             r + 1, k, obs_sv[k], exp_sv[k]);
                end
            end
            read_pots();
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if (obs_pot[i] !== m_pot[i]) begin
                    n_fail++;
                    $display("FAIL leak step%0d pot[%0d]=%0d required %0d",
                             r + 1, i, obs_pot[i], m_pot[i]);
                end
            end
        end
    endtask

    task automatic test_floor_saturation();
        apply_reset();
        send(3, -500);
        send(3, -500);
        for (int j = 0; j < 5; j++) send(0, 511);
        read_pots();
        n_cmp++;
        if (obs_pot[0] !== m_pot[0] || obs_pot[3] !== m_pot[3]) begin
            n_fail++;
            $display("FAIL sat pre-step pot0=%0d pot3=%0d required %0d %0d",
                     obs_pot[0], obs_pot[3], m_pot[0], m_pot[3]);
        end
        do_sweep(-1, 0, 0, 0);
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if (obs_sv[k] !== exp_sv[k] || (exp_sv[k] && obs_si[k] !== k)) begin
                n_fail++;
                $display("FAIL sat slot%0d sv=%0b idx=%0d required sv=%0b idx=%0d",
                         k, obs_sv[k], obs_si[k], exp_sv[k], k);
            end
        end
        read_pots();
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (obs_pot[i] !== m_pot[i]) begin
                n_fail++;
                $display("FAIL sat pot[%0d]=%0d required %0d", i, obs_pot[i], m_pot[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        send(1, 180);
        do_sweep(-1, 1, 1, 100);
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if (obs_sv[k] !== exp_sv[k] || (exp_sv[k] && obs_si[k] !== k)) begin
                n_fail++;
                $display("FAIL b2b slot%0d sv=%0b idx=%0d required sv=%0b idx=%0d",
                         k, obs_sv[k], obs_si[k], exp_sv[k], k);
            end
        end
    endtask

    task automatic test_random();
        int ns, ri, rc;
        apply_reset();
        for (int r = 0; r < 20; r++) begin
            ns = int'($urandom_range(0, 5));
            for (int j = 0; j < ns; j++) begin
                ri = int'($urandom_range(0, N - 1));
                rc = int'($urandom_range(0, 1023)) - 512;
                send(ri, rc);
            end
            do_sweep(-1, 0, 0, 0);
            for (int k = 0; k < N; k++) begin
                n_cmp++;
                if (obs_sv[k] !== exp_sv[k] || (exp_sv[k] && obs_si[k] !== k) ||
                    obs_done[k] !== (k == N - 1)) begin
                    n_fail++;
                    $display("FAIL rand round%0d slot%0d sv=%0b idx=%0d done=%0b required sv=%0b idx=%0d",
                             r, k, obs_sv[k], obs_si[k], obs_done[k], exp_sv[k], k);
                end
            end
            read_pots();
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if (obs_pot[i] !== m_pot[i]) begin
                    n_fail++;
                    $display("FAIL rand round%0d pot[%0d]=%0d required %0d",
                             r, i, obs_pot[i], m_pot[i]);
                end
            end
        end
    endtask

    task automatic test_overrun();
        int extra;
        apply_reset();
        send(1, 250);
        do_sweep(1, 0, 0, 0);
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if (obs_sv[k] !== exp_sv[k] || obs_done[k] !== (k == N - 1)) begin
                n_fail++;
                $display("FAIL ovr slot%0d sv=%0b done=%0b required sv=%0b done=%0b",
                         k, obs_sv[k], obs_done[k], exp_sv[k], k == N - 1);
            end
        end
        n_cmp++;
        if (overrun !== m_ovr) begin
            n_fail++;
            $display("FAIL ovr flag=%0b required %0b", overrun, m_ovr);
        end
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (!in_ready || upd_done || spike_valid) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL ovr extra-sweep busy cycles=%0d required 0", extra);
        end
    endtask

    // Leaves overrun set from the previous test so its clearing is visible.
    task automatic test_reset_mid_sweep();
        int late;
        send(3, 250);
        send(0, 100);
        @(negedge clk);
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        n_cmp++;
        if ({spike_valid, upd_done, overrun, in_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL midrst outputs sv/done/ovr/rdy=%b required 0001",
                     {spike_valid, upd_done, overrun, in_ready});
        end
        late = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (spike_valid || upd_done) late++;
        end
        n_cmp++;
        if (late !== 0) begin
            n_fail++;
            $display("FAIL midrst late events=%0d required 0", late);
        end
        read_pots();
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (obs_pot[i] !== m_pot[i]) begin
                n_fail++;
                $display("FAIL midrst pot[%0d]=%0d required %0d", i, obs_pot[i], m_pot[i]);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fire();
        test_refractory();
        test_leak_negative();
        test_floor_saturation();
        test_back_to_back();
        test_random();
        test_overrun();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
